// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, default widths and the iteration-counter sizing helper.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    localparam int DIV_W     = 16;
    localparam int DIV_ZW    = 2 * DIV_W;
    localparam int DIV_STEPS = 1;

    // Counter must hold the full iteration count, not just count-1.
    function automatic int cnt_width(input int zw, input int steps);
        return $clog2(zw / steps + 1);
    endfunction

    localparam int DIV_CW = cnt_width(DIV_ZW, DIV_STEPS);

    localparam logic [DIV_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DIV_W-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step on magnitudes.
// Shifts {rem,quo} left by one, trial-subtracts the divisor and restores on borrow.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0]   rem_in,
    input  logic [2*W-1:0] quo_in,
    input  logic [W-1:0]   divisor,
    output logic [W-1:0]   rem_out,
    output logic [2*W-1:0] quo_out
);

    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         borrow;

    // The shifted remainder needs W+1 bits; after a successful subtract it fits back in W.
    always_comb begin
        rem_sh  = {rem_in, quo_in[2*W-1]};
        borrow  = rem_sh < {1'b0, divisor};
        diff    = rem_sh[W-1:0] - divisor;
        rem_out = borrow ? rem_sh[W-1:0] : diff;
        quo_out = {quo_in[2*W-2:0], ~borrow};
    end

endmodule

// File: rtl/div32by16_seq.sv
// Sequential signed divider, 2W-bit dividend by W-bit divisor, restoring on magnitudes.
// Quotient truncates toward zero, remainder follows the dividend sign; saturates on overflow.
import div_pkg::*;

module div32by16_seq #(
    parameter int W     = DIV_W,
    parameter int STEPS = DIV_STEPS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2*W-1:0]   i_z,
    input  logic [W-1:0]     i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_q,
    output logic [W-1:0]     o_r,
    output logic             o_div0,
    output logic             o_ovf
);

    localparam int ZW    = 2 * W;
    localparam int ITERS = ZW / STEPS;
    localparam int CW    = cnt_width(ZW, STEPS);

    localparam logic [CW-1:0] ITERS_C  = CW'(ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [W-1:0]  Q_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  Q_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [ZW-1:0] MAG_NEG  = ZW'(1) << (W - 1);
    localparam logic [ZW-1:0] MAG_POS  = MAG_NEG - ZW'(1);

    state_t         state;
    state_t         state_nx;
    logic           accept;

    logic [ZW-1:0]  z_reg;
    logic [W-1:0]   b_reg;
    logic [ZW-1:0]  quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   bmag;
    logic [CW-1:0]  cnt;

    logic           sz;
    logic           sb;
    logic           q_neg;
    logic           b_zero;

    logic [W-1:0]   rem_c [0:STEPS];
    logic [ZW-1:0]  quo_c [0:STEPS];

    assign sz     = z_reg[ZW-1];
    assign sb     = b_reg[W-1];
    assign q_neg  = sz ^ sb;
    assign b_zero = (b_reg == '0);

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    assign rem_c[0] = rem;
    assign quo_c[0] = quo;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        div_step #(.W(W)) u_step (
            .rem_in  (rem_c[s]),
            .quo_in  (quo_c[s]),
            .divisor (bmag),
            .rem_out (rem_c[s+1]),
            .quo_out (quo_c[s+1])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    accept   = 1'b1;
                    state_nx = PREP;
                end
            end
            PREP:    state_nx = b_zero ? FIX : ITER;
            ITER:    if (cnt == CNT_LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            z_reg  <= '0;
            b_reg  <= '0;
            quo    <= '0;
            rem    <= '0;
            bmag   <= '0;
            cnt    <= '0;
            o_q    <= '0;
            o_r    <= '0;
            o_div0 <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        z_reg  <= i_z;
                        b_reg  <= i_b;
                        o_q    <= '0;
                        o_r    <= '0;
                        o_div0 <= 1'b0;
                        o_ovf  <= 1'b0;
                    end
                end
                PREP: begin
                    // Unsigned negation keeps -2^(ZW-1) and -2^(W-1) exact as magnitudes.
                    quo  <= sz ? -z_reg : z_reg;
                    bmag <= sb ? -b_reg : b_reg;
                    rem  <= '0;
                    cnt  <= ITERS_C;
                end
                ITER: begin
                    quo <= quo_c[STEPS];
                    rem <= rem_c[STEPS];
                    cnt <= cnt - CNT_LAST;
                end
                FIX: begin
                    if (b_zero) begin
                        o_div0 <= 1'b1;
                        o_ovf  <= 1'b0;
                        o_q    <= sz ? Q_MIN : Q_MAX;
                        o_r    <= z_reg[W-1:0];
                    end else begin
                        o_div0 <= 1'b0;
                        o_r    <= sz ? -rem : rem;
                        if (q_neg) begin
                            o_ovf <= (quo > MAG_NEG);
                            o_q   <= (quo > MAG_NEG) ? Q_MIN : -quo[W-1:0];
                        end else begin
                            o_ovf <= (quo > MAG_POS);
                            o_q   <= (quo > MAG_POS) ? Q_MAX : quo[W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32by16_seq.sv
// Directed bench for div32by16_seq; runs STEPS=1,2,4 instances side by side on shared inputs.
module tb_div32by16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready_in;
    logic [31:0] z;
    logic [15:0] b;

    logic        rdy [3];
    logic        vld [3];
    logic        ovf [3];
    logic        d0  [3];
    logic [15:0] q   [3];
    logic [15:0] r   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div32by16_seq #(.W(16), .STEPS(1 << g)) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_valid (valid),
            .o_ready (rdy[g]),
            .i_z     (z),
            .i_b     (b),
            .o_valid (vld[g]),
            .i_ready (ready_in),
            .o_q     (q[g]),
            .o_r     (r[g]),
            .o_div0  (d0[g]),
            .o_ovf   (ovf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, {31'd0, rdy[0] & rdy[1] & rdy[2]}, 32'd1);
    endtask

    task automatic do_op(input logic [31:0] zv, input logic [15:0] bv,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic eovf, input logic ediv0, input string tag);
        int          lat [3];
        logic        got [3];
        logic [15:0] cq  [3];
        logic [15:0] cr  [3];
        logic        cov [3];
        logic        cd0 [3];
        int          cyc;
        wait_idle(tag);
        valid    = 1'b1;
        z        = zv;
        b        = bv;
        ready_in = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 3; k++) begin
            got[k] = 1'b0; lat[k] = 0; cq[k] = '0; cr[k] = '0; cov[k] = 1'b0; cd0[k] = 1'b0;
        end
        while (!(got[0] && got[1] && got[2]) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (!got[k] && vld[k]) begin
                    got[k] = 1'b1; lat[k] = cyc;
                    cq[k] = q[k]; cr[k] = r[k]; cov[k] = ovf[k]; cd0[k] = d0[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_s%0d_done", tag, 1 << k), {31'd0, got[k]}, 32'd1);
            chk($sformatf("%s_s%0d_lat", tag, 1 << k), lat[k], ediv0 ? 32'd2 : 32'(2 + 32 / (1 << k)));
            chk($sformatf("%s_s%0d_q", tag, 1 << k), {16'd0, cq[k]}, {16'd0, eq});
            chk($sformatf("%s_s%0d_r", tag, 1 << k), {16'd0, cr[k]}, {16'd0, er});
            chk($sformatf("%s_s%0d_ovf", tag, 1 << k), {31'd0, cov[k]}, {31'd0, eovf});
            chk($sformatf("%s_s%0d_div0", tag, 1 << k), {31'd0, cd0[k]}, {31'd0, ediv0});
        end
    endtask

    initial begin
        int          cyc;
        int          ai;
        int          bi;
        int          edge_a [5];
        int          edge_b [4];
        logic [31:0] zz;

        rst = 1'b1; valid = 1'b0; ready_in = 1'b0; z = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_s%0d_rdy", 1 << k), {31'd0, rdy[k]}, 32'd1);
            chk($sformatf("rst_s%0d_vld", 1 << k), {31'd0, vld[k]}, 32'd0);
        end
        chk("rst_q", {16'd0, q[0]}, 32'd0);
        chk("rst_r", {16'd0, r[0]}, 32'd0);
        chk("rst_ovf", {31'd0, ovf[0]}, 32'd0);
        chk("rst_div0", {31'd0, d0[0]}, 32'd0);

        do_op(32'd1000,        16'd7,      16'h008E, 16'h0006, 1'b0, 1'b0, "pp");
        do_op(-32'sd1000,      16'd7,      16'hFF72, 16'hFFFA, 1'b0, 1'b0, "np");
        do_op(32'd1000,        -16'sd7,    16'hFF72, 16'h0006, 1'b0, 1'b0, "pn");
        do_op(-32'sd1000,      -16'sd7,    16'h008E, 16'hFFFA, 1'b0, 1'b0, "nn");
        do_op(32'd5,           16'd0,      16'h7FFF, 16'h0005, 1'b0, 1'b1, "d0p");
        do_op(-32'sd5,         16'd0,      16'h8000, 16'hFFFB, 1'b0, 1'b1, "d0n");
        do_op(32'd65536,       16'd1,      16'h7FFF, 16'h0000, 1'b1, 1'b0, "ovfp");
        do_op(-32'sd32768,     16'd1,      16'h8000, 16'h0000, 1'b0, 1'b0, "minq");
        do_op(32'h8000_0000,   16'hFFFF,   16'h7FFF, 16'h0000, 1'b1, 1'b0, "ovfmin");
        do_op(32'd32769,       -16'sd1,    16'h8000, 16'h0000, 1'b1, 1'b0, "ovfn");

        // Result held with downstream stalled; extra requests must be ignored.
        wait_idle("hs");
        valid = 1'b1; z = 32'd1000; b = 16'd7; ready_in = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        cyc = 0;
        while (!vld[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hs_lat", cyc, 32'd34);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; z = 32'd5; b = 16'd0;
            chk("hs_vld", {31'd0, vld[0]}, 32'd1);
            chk("hs_rdy", {31'd0, rdy[0]}, 32'd0);
            chk("hs_q", {16'd0, q[0]}, 32'h008E);
            chk("hs_r", {16'd0, r[0]}, 32'h0006);
            @(posedge clk); #1;
        end
        valid = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        chk("hs_vld_drop", {31'd0, vld[0]}, 32'd0);
        chk("hs_rdy_back", {31'd0, rdy[0]}, 32'd1);
        chk("hs_q_hold", {16'd0, q[0]}, 32'h008E);

        // Abort mid-iteration.
        wait_idle("ab");
        valid = 1'b1; z = -32'sd1000; b = 16'd7;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ab_vld", {31'd0, vld[0]}, 32'd0);
        chk("ab_rdy", {31'd0, rdy[0]}, 32'd1);
        chk("ab_q", {16'd0, q[0]}, 32'd0);
        chk("ab_r", {16'd0, r[0]}, 32'd0);
        do_op(-32'sd1000, 16'd7, 16'hFF72, 16'hFFFA, 1'b0, 1'b0, "ab_next");

        // Round trip through a multiply: quotient recovers the operand exactly.
        edge_a = '{32767, -32768, -1, 0, 1};
        edge_b = '{32767, -32768, -1, 1};
        foreach (edge_a[i]) begin
            foreach (edge_b[j]) begin
                zz = 32'(edge_a[i] * edge_b[j]);
                do_op(zz, 16'(edge_b[j]), 16'(edge_a[i]), 16'h0000, 1'b0, 1'b0,
                      $sformatf("rt_e%0d_%0d", i, j));
            end
        end
        for (int n = 0; n < 20; n++) begin
            ai = int'($urandom_range(0, 65535)) - 32768;
            bi = int'($urandom_range(0, 65535)) - 32768;
            if (bi == 0) bi = 3;
            zz = 32'(ai * bi);
            do_op(zz, 16'(bi), 16'(ai), 16'h0000, 1'b0, 1'b0, $sformatf("rt_r%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
